battle_msg_typer: RTL and testbench
===================================

# battle_msg_typer

Sequencer for the battle message line ("ENEMY <NAME> USED <MOVE>"). It reveals the message one character at a time, paced by video frames, then holds the full line before signalling completion. It sits upstream of the per-string text generators (enemy, name, "USED", move-name) and the font lookup. The color mapper compares each generator's character index against this block's per-segment visible counts and blanks unrevealed glyphs.

## Interface
Parameters:
- FRAMES_PER_CHAR, 2, frame ticks between successive character reveals (1..15)
- HOLD_FRAMES, 90, frame ticks the full message stays up before completion (1..255)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  vertical-sync level from the VGA controller; treated as asynchronous
- start  in  1  level; a message begins when sampled high in IDLE
- skip  in  1  button level; only its rising edge acts
- is_enemy  in  1  prefix "ENEMY " when 1
- poke_id  in  3  attacking Pokémon
- move_id  in  5  move used (0..25)
- busy  out  1  high in TYPE and HOLD
- msg_valid  out  1  message line should be drawn
- done  out  1  one-cycle pulse when the message completes
- reveal_count  out  6  characters revealed so far (0..32)
- msg_len  out  6  total length of the latched message, 26 or 32
- is_enemy_q, poke_id_q, move_id_q  out  1/3/5  values latched at start
- enemy_chars  out  3  visible characters of "ENEMY "
- name_chars  out  4  visible characters of the name segment
- used_chars  out  3  visible characters of "USED "
- move_chars  out  4  visible characters of the move segment

## Operation
- Segments, in order: ENEMY (6, present only if is_enemy_q), NAME (9), USED (5), MOVE (12). Pad spaces count as characters.
- msg_len = 26 + (is_enemy_q ? 6 : 0).
- Segment counts are combinational from reveal_count, with E = is_enemy_q ? 6 : 0:
  - enemy_chars = min(reveal_count, E)
  - name_chars = clamp(reveal_count − E, 0, 9)
  - used_chars = clamp(reveal_count − E − 9, 0, 5)
  - move_chars = clamp(reveal_count − E − 14, 0, 12)
  - All arithmetic is done at 7 bits signed so negatives clamp to 0.
- FSM states:
  - IDLE: start=1 latches is_enemy/poke_id/move_id, clears reveal_count and the frame counter, and enters TYPE. start and skip in the same cycle: start wins, skip is discarded.
  - TYPE: each frame tick increments the frame counter. When it reaches FRAMES_PER_CHAR, reveal_count increments and the counter clears. When reveal_count reaches msg_len, go to HOLD with the counter cleared. A skip edge sets reveal_count = msg_len and enters HOLD on the next cycle.
  - HOLD: each frame tick increments the counter. On reaching HOLD_FRAMES, or on a new skip edge, pulse done for one cycle, clear msg_valid, and return to IDLE.
- In TYPE/HOLD, start is ignored and latched IDs are unaffected by input changes.
- A skip held across the TYPE→HOLD transition does not end HOLD; a new rising edge is required.
- msg_valid = 1 in TYPE and HOLD, 0 in IDLE.

## Timing
- Reset (asynchronous): state IDLE. All outputs 0, including msg_len and the latched IDs. done is not pulsed.
- frame_clk passes through a 2-flop synchronizer and a rising-edge detector, producing a one-cycle frame_tick 3 Clk cycles after the edge. skip uses the same synchronizer and edge-detect structure.
- start is sampled at edge t; busy, msg_valid and the latched IDs are valid from t+1, with reveal_count = 0.
- reveal_count updates in the same cycle frame_tick is high, visible the following cycle. Segment counts follow reveal_count combinationally.
- The first character appears FRAMES_PER_CHAR ticks after entry to TYPE. A full message takes msg_len × FRAMES_PER_CHAR ticks, then HOLD_FRAMES ticks.
- done is high exactly one cycle, and that cycle is the first with busy = 0.
- A new start may be accepted in the cycle after done.

## Structure
- Package battle_text_pkg holds:
  - the typedef enum {IDLE, TYPE, HOLD} state_t
  - localparams ENEMY_LEN=6, NAME_LEN=9, USED_LEN=5, MOVE_LEN=12, MSG_MAX=32
  - these constants are shared with the text generators and the color mapper.
- Sub-module sync_edge (2-flop synchronizer plus rising-edge pulse), instantiated twice: frame_clk and skip.

## Test plan
Bench uses FRAMES_PER_CHAR=2, HOLD_FRAMES=4.
- Reset asserted mid-run → every output is 0 asynchronously, before the next Clk edge.
- start with is_enemy=1, poke_id=5, move_id=12 → msg_len=32. After 64 ticks reveal_count=32. After 4 more ticks done pulses for 1 cycle, then busy=0 and msg_valid=0.
- start with is_enemy=0, stopped at reveal_count=10 → segment counts 0/9/1/0. At reveal_count=26 → 0/9/5/12.
- skip edge after 3 ticks → next cycle reveal_count=32 and state HOLD. Holding skip high does not end HOLD; release then re-press → done.
- start pulsed and poke_id changed to 2 during TYPE → poke_id_q stays 5, progress unaffected. start and skip together in IDLE → message starts and does not skip.
- Reset at reveal_count=7 in TYPE → reveal_count=0, state IDLE, done never pulses. A subsequent start behaves normally.

Source files
------------

// File: rtl/battle_text_pkg.sv
// Constants and types shared by the battle message sequencer, the text generators and the color mapper.
package battle_text_pkg;

    typedef enum logic [1:0] {IDLE, TYPE, HOLD} state_t;

    localparam int unsigned ENEMY_LEN = 6;
    localparam int unsigned NAME_LEN  = 9;
    localparam int unsigned USED_LEN  = 5;
    localparam int unsigned MOVE_LEN  = 12;
    localparam int unsigned MSG_MAX   = 32;

    localparam int unsigned CNT_W = 6;
    localparam int unsigned SEG_W = 4;

    // Clamp a signed character offset into 0..lim for a segment's visible count.
    function automatic logic [SEG_W-1:0] seg_clamp(input logic signed [6:0] v,
                                                   input logic signed [6:0] lim);
        if (v < 7'sd0)
            return '0;
        else if (v > lim)
            return SEG_W'(lim);
        else
            return SEG_W'(v);
    endfunction

endpackage

// File: rtl/battle_msg_typer_if.sv
// Control inputs and status/visibility outputs of the battle message sequencer.
interface battle_msg_typer_if;
    import battle_text_pkg::*;

    logic             frame_clk;
    logic             start;
    logic             skip;
    logic             is_enemy;
    logic [2:0]       poke_id;
    logic [4:0]       move_id;

    logic             busy;
    logic             msg_valid;
    logic             done;
    logic [CNT_W-1:0] reveal_count;
    logic [CNT_W-1:0] msg_len;
    logic             is_enemy_q;
    logic [2:0]       poke_id_q;
    logic [4:0]       move_id_q;
    logic [2:0]       enemy_chars;
    logic [SEG_W-1:0] name_chars;
    logic [2:0]       used_chars;
    logic [SEG_W-1:0] move_chars;

    modport master (
        output frame_clk, start, skip, is_enemy, poke_id, move_id,
        input  busy, msg_valid, done, reveal_count, msg_len,
               is_enemy_q, poke_id_q, move_id_q,
               enemy_chars, name_chars, used_chars, move_chars
    );

    modport slave (
        input  frame_clk, start, skip, is_enemy, poke_id, move_id,
        output busy, msg_valid, done, reveal_count, msg_len,
               is_enemy_q, poke_id_q, move_id_q,
               enemy_chars, name_chars, used_chars, move_chars
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered one-cycle rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic [2:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            pulse <= 1'b0;
        end else begin
            sr    <= {sr[1:0], async_in};
            pulse <= sr[1] & ~sr[2];
        end
    end

endmodule

// File: rtl/battle_msg_typer.sv
// Frame-paced reveal of "ENEMY <NAME> USED <MOVE>", then a hold period before signalling done.
module battle_msg_typer
    import battle_text_pkg::*;
#(
    parameter int unsigned FRAMES_PER_CHAR = 2,
    parameter int unsigned HOLD_FRAMES     = 90
) (
    input  logic               Clk,
    input  logic               Reset,
    battle_msg_typer_if.slave  bus
);

    localparam int unsigned FCNT_W = 8;
    localparam logic signed [6:0] ENEMY_S = 7'(ENEMY_LEN);
    localparam logic signed [6:0] NAME_S  = 7'(NAME_LEN);
    localparam logic signed [6:0] USED_S  = 7'(USED_LEN);
    localparam logic signed [6:0] MOVE_S  = 7'(MOVE_LEN);

    state_t            state;
    logic [FCNT_W-1:0] fcnt;
    logic              frame_tick;
    logic              skip_tick;
    logic signed [6:0] rv;
    logic signed [6:0] ev;

    sync_edge u_frame_sync (
        .clk      (Clk),
        .rst      (Reset),
        .async_in (bus.frame_clk),
        .pulse    (frame_tick)
    );

    sync_edge u_skip_sync (
        .clk      (Clk),
        .rst      (Reset),
        .async_in (bus.skip),
        .pulse    (skip_tick)
    );

    // Sequencer; a skip edge coinciding with start in IDLE is dropped because IDLE ignores skip.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state            <= IDLE;
            fcnt             <= '0;
            bus.busy         <= 1'b0;
            bus.msg_valid    <= 1'b0;
            bus.done         <= 1'b0;
            bus.reveal_count <= '0;
            bus.msg_len      <= '0;
            bus.is_enemy_q   <= 1'b0;
            bus.poke_id_q    <= '0;
            bus.move_id_q    <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.is_enemy_q   <= bus.is_enemy;
                        bus.poke_id_q    <= bus.poke_id;
                        bus.move_id_q    <= bus.move_id;
                        bus.msg_len      <= bus.is_enemy ? CNT_W'(MSG_MAX)
                                                         : CNT_W'(MSG_MAX - ENEMY_LEN);
                        bus.reveal_count <= '0;
                        fcnt             <= '0;
                        bus.busy         <= 1'b1;
                        bus.msg_valid    <= 1'b1;
                        state            <= TYPE;
                    end
                end
                TYPE: begin
                    if (skip_tick) begin
                        bus.reveal_count <= bus.msg_len;
                        fcnt             <= '0;
                        state            <= HOLD;
                    end else if (frame_tick) begin
                        if (fcnt == FCNT_W'(FRAMES_PER_CHAR - 1)) begin
                            fcnt             <= '0;
                            bus.reveal_count <= CNT_W'(bus.reveal_count + CNT_W'(1));
                            if (CNT_W'(bus.reveal_count + CNT_W'(1)) == bus.msg_len)
                                state <= HOLD;
                        end else begin
                            fcnt <= FCNT_W'(fcnt + FCNT_W'(1));
                        end
                    end
                end
                HOLD: begin
                    if (skip_tick ||
                        (frame_tick && fcnt == FCNT_W'(HOLD_FRAMES - 1))) begin
                        bus.done      <= 1'b1;
                        bus.busy      <= 1'b0;
                        bus.msg_valid <= 1'b0;
                        fcnt          <= '0;
                        state         <= IDLE;
                    end else if (frame_tick) begin
                        fcnt <= FCNT_W'(fcnt + FCNT_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-segment visible counts; signed math so offsets before a segment clamp to zero.
    always_comb begin
        rv              = signed'({1'b0, bus.reveal_count});
        ev              = bus.is_enemy_q ? ENEMY_S : 7'sd0;
        bus.enemy_chars = 3'(seg_clamp(rv, ev));
        bus.name_chars  = seg_clamp(rv - ev, NAME_S);
        bus.used_chars  = 3'(seg_clamp(rv - ev - NAME_S, USED_S));
        bus.move_chars  = seg_clamp(rv - ev - NAME_S - USED_S, MOVE_S);
    end

endmodule

// File: tb/tb_battle_msg_typer.sv
// Self-checking bench for battle_msg_typer: directed scenarios plus randomized messages against a model.
module tb_battle_msg_typer;
    import battle_text_pkg::*;

    localparam int unsigned FPC = 2;
    localparam int unsigned HF  = 4;

    logic Clk;
    logic Reset;

    battle_msg_typer_if bus();

    battle_msg_typer #(.FRAMES_PER_CHAR(FPC), .HOLD_FRAMES(HF)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;

    // done pulse monitor: count pulses and flag any that are wide or not the first idle cycle
    int   done_cnt = 0;
    int   done_bad = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    always @(negedge Clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (bus.busy !== 1'b0 || bus.msg_valid !== 1'b0 ||
                prev_busy !== 1'b1 || prev_done === 1'b1)
                done_bad++;
        end
        prev_busy = bus.busy;
        prev_done = bus.done;
    end

    // reference model: message progress expressed in frame ticks since start
    bit m_active = 0;
    bit m_en = 0;
    bit m_skipped = 0;
    int m_len = 0, m_reveal = 0, m_ticks = 0, m_hold = 0, m_done_exp = 0;
    int m_poke = 0, m_move = 0;

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int seg_exp(input int k);
        int lens[4];
        int c[4];
        int pos;
        int s;
        lens = '{(m_en ? 6 : 0), 9, 5, 12};
        c    = '{0, 0, 0, 0};
        for (int i = 0; i < m_reveal; i++) begin
            pos = i;
            s   = 0;
            while (s < 3 && pos >= lens[s]) begin
                pos -= lens[s];
                s++;
            end
            c[s]++;
        end
        return c[k];
    endfunction

    task automatic model_start(input bit ie, input int p, input int m);
        m_active  = 1;
        m_en      = ie;
        m_len     = ie ? 32 : 26;
        m_reveal  = 0;
        m_ticks   = 0;
        m_hold    = 0;
        m_skipped = 0;
        m_poke    = p;
        m_move    = m;
    endtask

    task automatic model_tick();
        if (!m_active) return;
        if (m_skipped || m_ticks >= m_len * int'(FPC)) begin
            m_hold++;
        end else begin
            m_ticks++;
            m_reveal = m_ticks / int'(FPC);
        end
        if (m_hold == int'(HF)) begin
            m_active = 0;
            m_done_exp++;
        end
    endtask

    task automatic model_skip();
        if (!m_active) return;
        if (m_reveal < m_len) begin
            m_reveal  = m_len;
            m_skipped = 1;
            m_hold    = 0;
        end else begin
            m_active = 0;
            m_done_exp++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".busy"}, bus.busy, m_active);
        chk({tag, ".msg_valid"}, bus.msg_valid, m_active);
        chk({tag, ".done_count"}, done_cnt, m_done_exp);
        if (m_active) begin
            chk({tag, ".reveal"}, bus.reveal_count, m_reveal);
            chk({tag, ".msg_len"}, bus.msg_len, m_len);
            chk({tag, ".enemy"}, bus.enemy_chars, seg_exp(0));
            chk({tag, ".name"}, bus.name_chars, seg_exp(1));
            chk({tag, ".used"}, bus.used_chars, seg_exp(2));
            chk({tag, ".move"}, bus.move_chars, seg_exp(3));
            chk({tag, ".is_enemy_q"}, bus.is_enemy_q, m_en);
            chk({tag, ".poke_id_q"}, bus.poke_id_q, m_poke);
            chk({tag, ".move_id_q"}, bus.move_id_q, m_move);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".msg_valid"}, bus.msg_valid, 0);
        chk({tag, ".done"}, bus.done, 0);
        chk({tag, ".reveal"}, bus.reveal_count, 0);
        chk({tag, ".msg_len"}, bus.msg_len, 0);
        chk({tag, ".is_enemy_q"}, bus.is_enemy_q, 0);
        chk({tag, ".poke_id_q"}, bus.poke_id_q, 0);
        chk({tag, ".move_id_q"}, bus.move_id_q, 0);
        chk({tag, ".segs"}, {bus.enemy_chars, bus.name_chars, bus.used_chars, bus.move_chars}, 0);
    endtask

    task automatic frame();
        bus.frame_clk = 1'b1;
        step(4);
        bus.frame_clk = 1'b0;
        step(4);
        model_tick();
    endtask

    task automatic press_skip();
        bus.skip = 1'b1;
        step(6);
        model_skip();
    endtask

    task automatic release_skip();
        bus.skip = 1'b0;
        step(4);
    endtask

    task automatic do_start(input bit ie, input int p, input int m);
        bus.is_enemy = ie;
        bus.poke_id  = 3'(p);
        bus.move_id  = 5'(m);
        bus.start    = 1'b1;
        step(1);
        bus.start    = 1'b0;
        model_start(ie, p, m);
        check_model("start");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ie;
        int skip_at;
        bus.frame_clk = 1'b0;
        bus.start     = 1'b0;
        bus.skip      = 1'b0;
        bus.is_enemy  = 1'b0;
        bus.poke_id   = '0;
        bus.move_id   = '0;
        Reset = 1'b1;
        step(2);
        check_zero("reset0");
        Reset = 1'b0;
        step(2);
        check_zero("post_reset");

        // enemy message, natural completion; start/ID changes mid-TYPE must be ignored
        do_start(1'b1, 5, 12);
        chk("A.msg_len32", bus.msg_len, MSG_MAX);
        for (int f = 1; f <= 64; f++) begin
            frame();
            if (f == 10) begin
                bus.start    = 1'b1;
                bus.poke_id  = 3'd2;
                bus.move_id  = 5'd3;
                bus.is_enemy = 1'b0;
                step(2);
                bus.start = 1'b0;
                chk("A.poke_id_q_kept", bus.poke_id_q, 5);
            end
            check_model("A.type");
        end
        chk("A.reveal32", bus.reveal_count, 32);
        for (int f = 1; f <= 4; f++) begin
            frame();
            check_model("A.hold");
        end
        chk("A.done_once", done_cnt, 1);

        // non-enemy message, segment boundaries
        do_start(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 25)));
        for (int f = 1; f <= 20; f++) begin
            frame();
            check_model("B.type");
        end
        chk("B.segs_at10", {bus.enemy_chars, bus.name_chars, bus.used_chars, bus.move_chars},
            {3'd0, 4'd9, 3'd1, 4'd0});
        for (int f = 1; f <= 32; f++) begin
            frame();
            check_model("B.type2");
        end
        chk("B.segs_at26", {bus.enemy_chars, bus.name_chars, bus.used_chars, bus.move_chars},
            {3'd0, 4'd9, 3'd5, 4'd12});
        for (int f = 1; f <= 4; f++) begin
            frame();
            check_model("B.hold");
        end

        // start with skip already high: no skip; then skip edge, held skip, re-press
        ie = 1'($urandom_range(0, 1));
        bus.skip = 1'b1;
        step(3);
        do_start(ie, int'($urandom_range(0, 7)), int'($urandom_range(0, 25)));
        step(4);
        check_model("C.noskip");
        release_skip();
        for (int f = 1; f <= 3; f++) begin
            frame();
            check_model("C.type");
        end
        press_skip();
        check_model("C.skip");
        chk("C.reveal_full", bus.reveal_count, ie ? 32 : 26);
        frame();
        frame();
        check_model("C.held");
        release_skip();
        check_model("C.released");
        press_skip();
        check_model("C.repress");
        release_skip();

        // reset mid-TYPE at reveal_count 7
        do_start(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 25)));
        for (int f = 1; f <= 14; f++) begin
            frame();
            check_model("D.type");
        end
        chk("D.reveal7", bus.reveal_count, 7);
        Reset = 1'b1;
        #1;
        check_zero("D.async_reset");
        step(2);
        Reset = 1'b0;
        m_active = 0;
        step(3);
        chk("D.no_done", done_cnt, m_done_exp);

        // randomized messages with a random skip point (possibly never)
        for (int r = 0; r < 4; r++) begin
            ie = 1'($urandom_range(0, 1));
            do_start(ie, int'($urandom_range(0, 7)), int'($urandom_range(0, 25)));
            skip_at = int'($urandom_range(0, (ie ? 32 : 26) * FPC + HF + 2));
            for (int f = 0; f < 200 && m_active; f++) begin
                if (f == skip_at) begin
                    press_skip();
                    release_skip();
                    check_model("R.skip");
                end else begin
                    frame();
                    check_model("R.frame");
                end
            end
        end

        chk("done_shape", done_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
